// File: rtl/icache_line_server.sv
`default_nettype none
// ============================================================================
// icache_line_server : direct-mapped read-only instruction cache serving
//                      128-bit lines, refilled over a 32-bit word-beat port.
// Revision           : 1.0
// ============================================================================
module icache_line_server #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  Pc_in,
    input  logic         Rd_en,
    input  logic         Abort,
    input  logic         Invalidate,
    output logic [127:0] Dout,
    output logic         Dout_valid,
    output logic         Busy,
    output logic         Mem_rd_req,
    output logic [31:0]  Mem_addr,
    input  logic         Mem_rd_ack,
    input  logic [31:0]  Mem_rd_data
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [1:0]            beat, beat_d;
    logic [27:0]           miss_line, miss_line_d;
    logic                  abort_seen, abort_seen_d;
    logic                  dv_reg, dv_d;
    logic [127:0]          dout_d;
    logic                  mem_rd_req_d;
    logic [31:0]           mem_addr_d;
    logic [LINES-1:0]      valid, valid_d;
    logic                  install;

    logic [127:0]          data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           fill0, fill1, fill2;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit;
    logic [127:0]          refill_line;
    logic                  unused_pc_bits;

    assign req_idx        = Pc_in[INDEX_BITS+3:4];
    assign req_tag        = Pc_in[31:INDEX_BITS+4];
    assign fill_idx       = miss_line[INDEX_BITS-1:0];
    assign unused_pc_bits = ^Pc_in[3:0];

    // A same-cycle Invalidate wins over a hit, so the request refills instead.
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !Invalidate;
    assign refill_line = {fill0, fill1, fill2, Mem_rd_data};

    assign Dout_valid = dv_reg & ~Abort;
    assign Busy       = (state != IDLE);

    always_comb begin
        state_d      = state;
        beat_d       = beat;
        miss_line_d  = miss_line;
        abort_seen_d = abort_seen;
        dv_d         = 1'b0;
        dout_d       = Dout;
        install      = 1'b0;

        case (state)
            IDLE: begin
                if (Rd_en && !Abort) begin
                    if (hit) begin
                        dout_d = data_mem[req_idx];
                        dv_d   = 1'b1;
                    end else begin
                        miss_line_d  = Pc_in[31:4];
                        beat_d       = 2'd0;
                        abort_seen_d = 1'b0;
                        state_d      = REFILL;
                    end
                end
            end
            REFILL: begin
                if (Abort) begin
                    abort_seen_d = 1'b1;
                end
                if (Mem_rd_ack) begin
                    beat_d = beat + 2'd1;
                    if (beat == 2'd3) begin
                        install = 1'b1;
                        dout_d  = refill_line;
                        dv_d    = !abort_seen && !Abort;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear-all first so a completing refill keeps its own line valid.
        valid_d = Invalidate ? '0 : valid;
        if (install) begin
            valid_d[fill_idx] = 1'b1;
        end

        mem_rd_req_d = (state_d == REFILL);
        mem_addr_d   = {miss_line_d, beat_d, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= 2'd0;
            miss_line  <= '0;
            abort_seen <= 1'b0;
            dv_reg     <= 1'b0;
            Dout       <= '0;
            Mem_rd_req <= 1'b0;
            Mem_addr   <= '0;
            valid      <= '0;
        end else begin
            state      <= state_d;
            beat       <= beat_d;
            miss_line  <= miss_line_d;
            abort_seen <= abort_seen_d;
            dv_reg     <= dv_d;
            Dout       <= dout_d;
            Mem_rd_req <= mem_rd_req_d;
            Mem_addr   <= mem_addr_d;
            valid      <= valid_d;
        end
    end

    // Line storage is not reset; the last beat goes straight into the line.
    always_ff @(posedge clk) begin
        if (state == REFILL && Mem_rd_ack) begin
            case (beat)
                2'd0:    fill0 <= Mem_rd_data;
                2'd1:    fill1 <= Mem_rd_data;
                2'd2:    fill2 <= Mem_rd_data;
                default: ;
            endcase
        end
        if (install) begin
            data_mem[fill_idx] <= refill_line;
            tag_mem[fill_idx]  <= miss_line[27:INDEX_BITS];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_line_server.sv
`default_nettype none
// tb_icache_line_server: scoreboard bench; a line-level cache model predicts each
// response and its cycle, a memory responder serves beats and checks addresses.
module tb_icache_line_server;

    localparam int INDEX_BITS = 4;
    localparam int LINES      = 1 << INDEX_BITS;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  Pc_in = '0;
    logic         Rd_en = 1'b0;
    logic         Abort = 1'b0;
    logic         Invalidate = 1'b0;
    logic [127:0] Dout;
    logic         Dout_valid;
    logic         Busy;
    logic         Mem_rd_req;
    logic [31:0]  Mem_addr;
    logic         Mem_rd_ack = 1'b0;
    logic [31:0]  Mem_rd_data = '0;

    icache_line_server #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .Pc_in       (Pc_in),
        .Rd_en       (Rd_en),
        .Abort       (Abort),
        .Invalidate  (Invalidate),
        .Dout        (Dout),
        .Dout_valid  (Dout_valid),
        .Busy        (Busy),
        .Mem_rd_req  (Mem_rd_req),
        .Mem_addr    (Mem_addr),
        .Mem_rd_ack  (Mem_rd_ack),
        .Mem_rd_data (Mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        logic [127:0] line;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          mem_wait = 0;
    int          req_cnt = 0;

    // Reference cache: which memory line each index holds, and whether it is valid.
    logic [27:0] res_line  [LINES];
    bit          res_valid [LINES];
    int          busy_until = 0;
    int          exp_req = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h4) return 32'h11 * {30'd0, a[3:2]} + 32'h11;
        return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    function automatic logic [127:0] line_data(input logic [27:0] ln);
        logic [31:0] b;
        b = {ln, 4'h0};
        return {mem_word(b), mem_word(b + 32'd4), mem_word(b + 32'd8), mem_word(b + 32'd12)};
    endfunction

    function automatic logic [31:0] rand_addr();
        int          tsel;
        logic [23:0] tag;
        tsel = $urandom_range(0, 4);
        tag  = (tsel == 4) ? 24'hABCDE1 : 24'(tsel);
        return {tag, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_inval();
        for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        Rd_en      = 1'b0;
        Abort      = 1'b0;
        Invalidate = 1'b0;
    endtask

    task automatic wait_idle();
        tick();
        while (cyc < busy_until) tick();
        if (exp_req >= 0) check("mem_req_cycles", req_cnt, exp_req);
        exp_req = -1;
    endtask

    // abort_off / inv_off: cycle offset after the request at which to pulse (0 = never).
    task automatic do_req(input logic [31:0] a, input int w, input bit inv_now,
                          input bit abort_now, input int abort_off, input int inv_off);
        int          c;
        int          idx;
        int          done_off;
        logic [27:0] ln;
        wait_idle();
        c          = cyc;
        ln         = a[31:4];
        idx        = int'(a[INDEX_BITS+3:4]);
        Pc_in      = a;
        Rd_en      = 1'b1;
        Abort      = abort_now;
        Invalidate = inv_now;
        req_cnt    = 0;
        if (inv_now) model_inval();
        if (abort_now) begin
            busy_until = c + 1;
            exp_req    = 0;
            return;
        end
        if (res_valid[idx] && res_line[idx] == ln) begin
            exp_q.push_back('{c + 1, line_data(ln)});
            busy_until = c + 1;
            exp_req    = 0;
            return;
        end
        mem_wait = w;
        for (int k = 0; k < 4; k++) addr_q.push_back({ln, k[1:0], 2'b00});
        done_off = 5 + 4 * w;
        if (abort_off < 1 || abort_off > done_off) exp_q.push_back('{c + done_off, line_data(ln)});
        for (int k = 1; k <= done_off; k++) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                Rd_en = 1'b1;
                Pc_in = $urandom;
            end
            if (k == abort_off) Abort = 1'b1;
            if (k == inv_off) Invalidate = 1'b1;
        end
        if (inv_off >= 1 && inv_off < done_off) model_inval();
        res_line[idx]  = ln;
        res_valid[idx] = 1'b1;
        if (inv_off == done_off) model_inval();
        busy_until = c + done_off + 1;
        exp_req    = 4 * (w + 1);
    endtask

    task automatic do_idle(input bit inv, input bit ab);
        wait_idle();
        Pc_in      = $urandom;
        Invalidate = inv;
        Abort      = ab;
        if (inv) model_inval();
        busy_until = cyc + 1;
    endtask

    task automatic do_reset_mid_refill(input logic [31:0] a);
        wait_idle();
        Pc_in    = a;
        Rd_en    = 1'b1;
        mem_wait = 0;
        for (int k = 0; k < 4; k++) addr_q.push_back({a[31:4], k[1:0], 2'b00});
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_dout", Dout, 128'd0);
        check("midrst_dout_valid", Dout_valid, 1'b0);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_mem_rd_req", Mem_rd_req, 1'b0);
        check("midrst_mem_addr", Mem_addr, 32'd0);
        addr_q.delete();
        model_inval();
        tick();
        reset      = 1'b0;
        busy_until = cyc;
        exp_req    = -1;
    endtask

    // Response monitor: every cycle the DUT's strobe must match the scoreboard head.
    initial begin
        bit   due;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("dout_valid", Dout_valid, due && !Abort);
            if (due) begin
                e = exp_q.pop_front();
                if (!Abort) check("dout", Dout, e.line);
            end
            if (Mem_rd_req) req_cnt++;
        end
    end

    // Memory responder: mem_wait idle cycles before each ack; junk acks when not requested.
    initial begin
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (Mem_rd_req && !reset) begin
                if (w >= mem_wait) begin
                    Mem_rd_ack  = 1'b1;
                    Mem_rd_data = mem_word(Mem_addr);
                    w = 0;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_addr: unexpected beat at %h, none required", Mem_addr);
                    end else begin
                        check("mem_addr", Mem_addr, addr_q.pop_front());
                    end
                end else begin
                    Mem_rd_ack  = 1'b0;
                    Mem_rd_data = $urandom;
                    w++;
                end
            end else begin
                Mem_rd_ack  = 1'($urandom_range(0, 1));
                Mem_rd_data = $urandom;
                w = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        int          w;
        int          ao;
        int          io;
        logic [31:0] a;
        model_inval();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", Dout, 128'd0);
        check("rst_dout_valid", Dout_valid, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_mem_rd_req", Mem_rd_req, 1'b0);
        check("rst_mem_addr", Mem_addr, 32'd0);
        reset      = 1'b0;
        busy_until = cyc + 1;

        // Cold miss with known memory contents
        do_req(32'h0000_0040, 0, 0, 0, 0, 0);
        wait_idle();
        check("cold_line", Dout, 128'h00000011_00000022_00000033_00000044);
        busy_until = cyc + 1;

        // Hit streaming and a neighbouring line
        do_req(32'h0000_0040, 0, 0, 0, 0, 0);
        do_req(32'h0000_004C, 0, 0, 0, 0, 0);
        do_req(32'h0000_0050, 0, 0, 0, 0, 0);
        do_req(32'h0000_0058, 0, 0, 0, 0, 0);
        do_req(32'h0000_0044, 0, 0, 0, 0, 0);

        // Conflict miss with two wait states per beat
        do_req(32'h0000_0140, 2, 0, 0, 0, 0);
        do_req(32'h0000_0148, 0, 0, 0, 0, 0);
        do_req(32'h0000_0040, 0, 0, 0, 0, 0);

        // Abort during beat 2, then the installed line hits
        do_req(32'h0000_0240, 1, 0, 0, 5, 0);
        do_req(32'h0000_0240, 0, 0, 0, 0, 0);

        // Invalidate while idle, during a refill, and together with a hit
        do_idle(1'b1, 1'b0);
        do_req(32'h0000_0240, 0, 0, 0, 0, 0);
        do_req(32'h0000_0340, 1, 0, 0, 0, 3);
        do_req(32'h0000_0340, 0, 0, 0, 0, 0);
        do_req(32'h0000_0240, 0, 0, 0, 0, 0);
        do_req(32'h0000_0340, 0, 1, 0, 0, 0);

        // Abort on the request cycle, and Abort masking a hit response
        do_req(32'h0000_0340, 0, 0, 1, 0, 0);
        do_req(32'h0000_0340, 0, 0, 0, 0, 0);
        do_idle(1'b0, 1'b1);

        // Async reset at beat 1 of a refill, then the same address misses
        do_idle(1'b1, 1'b0);
        do_reset_mid_refill(32'h0000_0040);
        do_req(32'h0000_0040, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            a  = rand_addr();
            w  = $urandom_range(0, 2);
            ao = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5 + 4 * w) : 0;
            io = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5 + 4 * w) : 0;
            if (r == 0) begin
                do_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (r == 1) begin
                do_req(a, w, 1'b1, 1'b0, ao, io);
            end else if (r == 2) begin
                do_req(a, w, 1'b0, 1'b1, 0, 0);
            end else begin
                do_req(a, w, 1'b0, 1'b0, ao, io);
            end
        end

        wait_idle();
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("mem_beats_drained", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_line_server.md
# icache_line_server

Direct-mapped, read-only instruction cache that serves 128-bit (4-instruction) lines to the instruction fetch queue. It accepts a fetch address and read enable from the queue and returns one line with a one-cycle valid strobe. On a miss, it refills the line from main memory over a 32-bit word-beat handshake. It sits between the fetch queue and the memory arbiter, and its fetch-side ports connect name-for-name to the queue's cache-side ports.

## Interface
- INDEX_BITS, 4, line index width (2^INDEX_BITS lines of 128 bits); tag width is 28-INDEX_BITS
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- Pc_in  in  32  fetch address; bits [3:0] ignored; index = Pc_in[INDEX_BITS+3:4]; tag = Pc_in[31:INDEX_BITS+4]
- Rd_en  in  1  fetch request, sampled each cycle
- Abort  in  1  jump/branch redirect; cancels the pending response
- Invalidate  in  1  one-cycle pulse that clears all valid bits
- Dout  out  128  line data; Dout[127:96] = word at byte offset 0, Dout[31:0] = word at offset 12
- Dout_valid  out  1  Dout holds the requested line this cycle
- Busy  out  1  high in REFILL and RESPOND (requests are ignored)
- Mem_rd_req  out  1  memory word read request
- Mem_addr  out  32  word address {miss_line[27:0], beat[1:0], 2'b00}
- Mem_rd_ack  in  1  Mem_rd_data valid; completes the current beat
- Mem_rd_data  in  32  returned word

## Operation
- Storage: data[2^INDEX_BITS] x128, tag[2^INDEX_BITS] x(28-INDEX_BITS), valid[2^INDEX_BITS] x1. Only valid is reset.
- FSM states: IDLE, REFILL, RESPOND. Reset state is IDLE.
- IDLE: a request is accepted when Rd_en & ~Abort.
  - Hit (valid[idx] && tag match): register data[idx] into Dout, set dv_reg=1, stay in IDLE.
  - Miss: latch miss_line=Pc_in[31:4], set beat=0, clear abort_seen, go to REFILL.
  - No request: dv_reg=0.
- REFILL:
  - Mem_rd_req=1 and Mem_addr = {miss_line, beat, 2'b00}, held stable until ack.
  - On Mem_rd_ack, store Mem_rd_data into fill word[beat] (beat 0 goes to bits [127:96]) and increment beat.
  - On the ack with beat==3, write data/tag/valid[idx]=1, load Dout with the assembled line, set dv_reg = ~abort_seen & ~Abort, and go to RESPOND.
  - Abort high in any REFILL cycle sets abort_seen. The refill still completes and the line is still installed.
- RESPOND: one cycle, then go to IDLE. Rd_en is ignored. dv_reg clears on exit.
- Dout_valid = dv_reg & ~Abort; Abort masks a response in the same cycle.
- Invalidate clears all valid bits at the next edge. In IDLE it takes priority over a same-cycle hit, which is treated as a miss. A refill in flight still sets its own valid bit on completion.
- Beat counter is 2 bits and wraps 3->0 only on completion.
- Mem_rd_ack outside REFILL is ignored.

## Timing
- Reset values: Dout=0, Dout_valid=0, Busy=0, Mem_rd_req=0, Mem_addr=0, all valid=0, state IDLE, beat=0.
- Reset asserted mid-refill: returns to IDLE at once and installs no partial line.
- Hit latency: request in cycle c gives Dout_valid in cycle c+1. Back-to-back hits sustain one line per cycle.
- Miss latency with zero-wait memory (ack in every REFILL cycle):
  - Mem_rd_req is high in cycles c+1..c+4.
  - Dout_valid is high in cycle c+5.
  - IDLE resumes in c+6.
- Each memory wait cycle adds one cycle to the miss latency.
- Mem_rd_req and Mem_addr are registered (from state and beat), never combinational from Mem_rd_ack.

## Test plan
- Cold miss: after reset, Rd_en=1 with Pc_in=0x0000_0040 and memory returning 0x11,0x22,0x33,0x44 with no waits.
  - Mem_addr = 0x40, 0x44, 0x48, 0x4C in cycles 1-4.
  - Dout_valid in cycle 5 with Dout = 0x00000011_00000022_00000033_00000044.
- Hit streaming: repeat 0x40, then 0x4C (same line), then 0x50 after it is filled.
  - Each hit gives Dout_valid exactly one cycle after the request, with no Mem_rd_req.
- Conflict and wait states: fill 0x040, then request 0x140 (same index 4 with INDEX_BITS=4, different tag), with ack delayed 2 cycles per beat.
  - Miss with Mem_rd_req high for 12 cycles.
  - Line 4 then holds the 0x140 data, and 0x040 misses again.
- Abort during refill: raise Abort for 1 cycle at beat 2.
  - No Dout_valid is produced.
  - A later request to the same address hits in 1 cycle.
- Invalidate: pulse Invalidate after filling 0x40; the next request to 0x40 takes the 5-cycle miss path. Also pulse Invalidate during a refill; the refilled line still hits afterward.
- Async reset at beat 1 of a refill: all outputs go to 0 immediately, and a re-request to the same address misses.
